// File: rtl/csr_file_pkg.sv
// Shared CSR addresses, exception codes, bus layouts and the masked-write helper
// for the LoongArch CSR file.
package csr_file_pkg;

  localparam int CSR_CTRL_LEN = 80;
  localparam int WB2CSR_LEN   = 81;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  localparam logic [31:0] CRMD_WMASK   = 32'h0000_01FF;
  localparam logic [31:0] PRMD_WMASK   = 32'h0000_0007;
  localparam logic [31:0] ECFG_WMASK   = 32'h0000_1BFF;
  localparam logic [31:0] ESTAT_WMASK  = 32'h0000_0003;
  localparam logic [31:0] EENTRY_WMASK = 32'hFFFF_FFC0;
  localparam logic [31:0] FULL_WMASK   = 32'hFFFF_FFFF;

  localparam logic [5:0] ECODE_ADE    = 6'h08;
  localparam logic [5:0] ECODE_ALE    = 6'h09;
  localparam logic [8:0] ESUBCODE_ADEF = 9'h000;
  localparam logic [8:0] ESUBCODE_ADEM = 9'h001;

  typedef struct packed {
    logic        re;
    logic        we;
    logic [13:0] num;
    logic [31:0] wmask;
    logic [31:0] wvalue;
  } csr_ctrl_t;

  typedef struct packed {
    logic        ertn;
    logic        wb_ex;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic [31:0] pc;
    logic [31:0] vaddr;
  } wb2csr_t;

  function automatic logic [31:0] csr_merge(input logic [31:0] old_val, input logic [31:0] wvalue,
                                            input logic [31:0] wmask, input logic [31:0] field_mask);
    logic [31:0] m;
    m = wmask & field_mask;
    return (old_val & ~m) | (wvalue & m);
  endfunction

endpackage

// File: rtl/csr_file_if.sv
// WB -> CSR request/response bundle: WB drives the request, the CSR file returns read data.
interface csr_file_if;
  import csr_file_pkg::*;

  logic                    wb_valid;
  logic [CSR_CTRL_LEN-1:0] csr_ctrl;
  logic [WB2CSR_LEN-1:0]   to_csr_in_bus;
  logic [31:0]             csr_rvalue;

  modport master (output wb_valid, output csr_ctrl, output to_csr_in_bus, input csr_rvalue);
  modport slave  (input wb_valid, input csr_ctrl, input to_csr_in_bus, output csr_rvalue);
endinterface

// File: rtl/csr_timer.sv
// Stable timer: holds TCFG, counts TVAL down and pulses fire when an enabled count reaches zero.
module csr_timer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        tcfg_we,
  input  logic [31:0] tcfg_wdata,
  output logic [31:0] tcfg,
  output logic [31:0] tval,
  output logic        fire
);
  logic [31:0] tcfg_r;
  logic [31:0] tval_r;
  logic        fire_s;

  // A reload from a TCFG write takes the place of a fire in the same cycle
  assign fire_s = ~tcfg_we & tcfg_r[0] & (tval_r == 32'h0000_0000);

  // TCFG/TVAL state: write-load, fire-reload or park, then plain countdown
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tcfg_r <= 32'h0000_0000;
      tval_r <= 32'hFFFF_FFFF;
    end else if (tcfg_we) begin
      tcfg_r <= tcfg_wdata;
      if (tcfg_wdata[0]) begin
        tval_r <= {tcfg_wdata[31:2], 2'b00};
      end
    end else if (fire_s) begin
      tval_r <= tcfg_r[1] ? {tcfg_r[31:2], 2'b00} : 32'hFFFF_FFFF;
    end else if (tcfg_r[0] && (tval_r != 32'hFFFF_FFFF)) begin
      tval_r <= tval_r - 32'd1;
    end
  end

  assign tcfg = tcfg_r;
  assign tval = tval_r;
  assign fire = fire_s;
endmodule

// File: rtl/csr_file.sv
// LoongArch CSR file: combinational reads, masked writes, exception/ERTN commit,
// timer and interrupt pending state.
module csr_file
  import csr_file_pkg::*;
#(
  parameter logic [31:0] TID_INIT = 32'h0000_0000,
  parameter int          HW_INT_W = 8
) (
  input  logic                clk,
  input  logic                resetn,
  csr_file_if.slave           wb,
  input  logic [HW_INT_W-1:0] hw_int_in,
  output logic [31:0]         ex_entry,
  output logic [31:0]         ertn_entry,
  output logic                has_int
);
  csr_ctrl_t   ctrl_s;
  wb2csr_t     exb_s;
  logic        ex_s, ertn_s, we_s;
  logic [7:0]  hw_s;
  logic        unused_ok_s;

  logic [8:0]  crmd_r;
  logic [2:0]  prmd_r;
  logic [12:0] ecfg_r;
  logic [12:0] is_r;
  logic [5:0]  ecode_r;
  logic [8:0]  esub_r;
  logic [31:0] era_r, badv_r, tid_r;
  logic [25:0] eentry_r;
  logic [31:0] save_r [0:3];

  logic [31:0] crmd_v_s, prmd_v_s, ecfg_v_s, estat_v_s, eentry_v_s;
  logic [31:0] tcfg_s, tval_s, rdata_s;
  logic        fire_s, ticlr_clr_s;

  assign ctrl_s      = csr_ctrl_t'(wb.csr_ctrl);
  assign exb_s       = wb2csr_t'(wb.to_csr_in_bus);
  assign hw_s        = 8'(hw_int_in);
  assign unused_ok_s = ctrl_s.re;

  // Exception beats ERTN, and either one drops a coinciding CSR write
  assign ex_s   = exb_s.wb_ex;
  assign ertn_s = exb_s.ertn & ~exb_s.wb_ex;
  assign we_s   = wb.wb_valid & ctrl_s.we & ~exb_s.wb_ex & ~exb_s.ertn;

  assign crmd_v_s   = {23'h0, crmd_r};
  assign prmd_v_s   = {29'h0, prmd_r};
  assign ecfg_v_s   = {19'h0, ecfg_r};
  assign estat_v_s  = {1'b0, esub_r, ecode_r, 3'b000, is_r};
  assign eentry_v_s = {eentry_r, 6'b00_0000};

  assign ticlr_clr_s = we_s & (ctrl_s.num == CSR_TICLR) & ctrl_s.wmask[0] & ctrl_s.wvalue[0];

  csr_timer u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .tcfg_we    (we_s & (ctrl_s.num == CSR_TCFG)),
    .tcfg_wdata (csr_merge(tcfg_s, ctrl_s.wvalue, ctrl_s.wmask, FULL_WMASK)),
    .tcfg       (tcfg_s),
    .tval       (tval_s),
    .fire       (fire_s)
  );

  // Architectural state: reset, exception/ERTN commit, masked writes, interrupt sampling
  always_ff @(posedge clk) begin
    if (!resetn) begin
      crmd_r   <= 9'h008;
      prmd_r   <= 3'h0;
      ecfg_r   <= 13'h0000;
      is_r     <= 13'h0000;
      ecode_r  <= 6'h00;
      esub_r   <= 9'h000;
      era_r    <= 32'h0000_0000;
      badv_r   <= 32'h0000_0000;
      eentry_r <= 26'h0;
      tid_r    <= TID_INIT;
      for (int i = 0; i < 4; i++) save_r[i] <= 32'h0000_0000;
    end else begin
      if (ex_s) begin
        prmd_r      <= crmd_r[2:0];
        crmd_r[2:0] <= 3'b000;
        ecode_r     <= exb_s.ecode;
        esub_r      <= exb_s.esubcode;
        era_r       <= exb_s.pc;
        if ((exb_s.ecode == ECODE_ADE) && (exb_s.esubcode == ESUBCODE_ADEF)) begin
          badv_r <= exb_s.pc;
        end else if ((exb_s.ecode == ECODE_ALE) ||
                     ((exb_s.ecode == ECODE_ADE) && (exb_s.esubcode == ESUBCODE_ADEM))) begin
          badv_r <= exb_s.vaddr;
        end
      end else if (ertn_s) begin
        crmd_r[2:0] <= prmd_r;
      end else if (we_s) begin
        case (ctrl_s.num)
          CSR_CRMD:   crmd_r   <= 9'(csr_merge(crmd_v_s, ctrl_s.wvalue, ctrl_s.wmask, CRMD_WMASK));
          CSR_PRMD:   prmd_r   <= 3'(csr_merge(prmd_v_s, ctrl_s.wvalue, ctrl_s.wmask, PRMD_WMASK));
          CSR_ECFG:   ecfg_r   <= 13'(csr_merge(ecfg_v_s, ctrl_s.wvalue, ctrl_s.wmask, ECFG_WMASK));
          CSR_ESTAT:  is_r[1:0] <= 2'(csr_merge(estat_v_s, ctrl_s.wvalue, ctrl_s.wmask, ESTAT_WMASK));
          CSR_ERA:    era_r    <= csr_merge(era_r, ctrl_s.wvalue, ctrl_s.wmask, FULL_WMASK);
          CSR_BADV:   badv_r   <= csr_merge(badv_r, ctrl_s.wvalue, ctrl_s.wmask, FULL_WMASK);
          CSR_EENTRY: eentry_r <= 26'(csr_merge(eentry_v_s, ctrl_s.wvalue, ctrl_s.wmask,
                                                EENTRY_WMASK) >> 6);
          CSR_SAVE0:  save_r[0] <= csr_merge(save_r[0], ctrl_s.wvalue, ctrl_s.wmask, FULL_WMASK);
          CSR_SAVE1:  save_r[1] <= csr_merge(save_r[1], ctrl_s.wvalue, ctrl_s.wmask, FULL_WMASK);
          CSR_SAVE2:  save_r[2] <= csr_merge(save_r[2], ctrl_s.wvalue, ctrl_s.wmask, FULL_WMASK);
          CSR_SAVE3:  save_r[3] <= csr_merge(save_r[3], ctrl_s.wvalue, ctrl_s.wmask, FULL_WMASK);
          CSR_TID:    tid_r    <= csr_merge(tid_r, ctrl_s.wvalue, ctrl_s.wmask, FULL_WMASK);
          default:    ;
        endcase
      end
      is_r[9:2] <= hw_s;
      // A timer fire in the same cycle overrides a TICLR clear
      if (fire_s) begin
        is_r[11] <= 1'b1;
      end else if (ticlr_clr_s) begin
        is_r[11] <= 1'b0;
      end
    end
  end

  // Read mux; unmapped addresses and TICLR read as zero
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (ctrl_s.num)
      CSR_CRMD:   rdata_s = crmd_v_s;
      CSR_PRMD:   rdata_s = prmd_v_s;
      CSR_ECFG:   rdata_s = ecfg_v_s;
      CSR_ESTAT:  rdata_s = estat_v_s;
      CSR_ERA:    rdata_s = era_r;
      CSR_BADV:   rdata_s = badv_r;
      CSR_EENTRY: rdata_s = eentry_v_s;
      CSR_SAVE0:  rdata_s = save_r[0];
      CSR_SAVE1:  rdata_s = save_r[1];
      CSR_SAVE2:  rdata_s = save_r[2];
      CSR_SAVE3:  rdata_s = save_r[3];
      CSR_TID:    rdata_s = tid_r;
      CSR_TCFG:   rdata_s = tcfg_s;
      CSR_TVAL:   rdata_s = tval_s;
      CSR_TICLR:  rdata_s = 32'h0000_0000;
      default:    rdata_s = 32'h0000_0000;
    endcase
  end

  assign wb.csr_rvalue = rdata_s;
  assign ex_entry      = eentry_v_s;
  assign ertn_entry    = era_r;
  assign has_int       = crmd_r[2] & (|(is_r & ecfg_r));
endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: table of single-cycle writes/exceptions with a read-back,
// plus hand sequences for exception/ERTN, periodic and one-shot timer, and mid-count reset.
module tb_csr_file;
  import csr_file_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  hw_int = 8'h00;
  logic [31:0] ex_entry, ertn_entry;
  logic        has_int;

  csr_file_if bus ();

  csr_file #(.TID_INIT(32'h1234_5678), .HW_INT_W(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .wb         (bus),
    .hw_int_in  (hw_int),
    .ex_entry   (ex_entry),
    .ertn_entry (ertn_entry),
    .has_int    (has_int)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, we, ex, ertn;
    logic [13:0] num;
    logic [31:0] wmask, wvalue;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic [31:0] pc, vaddr;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [13:0] rd;
    logic [31:0] exp;
    logic        exp_int;
    string       name;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;
  vec_t vt [0:17];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t wr(input logic [13:0] num, input logic [31:0] m, input logic [31:0] v);
    stim_t s;
    s = idle();
    s.valid = 1'b1; s.we = 1'b1; s.num = num; s.wmask = m; s.wvalue = v;
    return s;
  endfunction

  function automatic stim_t exc(input logic [5:0] ec, input logic [8:0] es,
                                input logic [31:0] pc, input logic [31:0] va);
    stim_t s;
    s = idle();
    s.valid = 1'b1; s.ex = 1'b1; s.ecode = ec; s.esub = es; s.pc = pc; s.vaddr = va;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    csr_ctrl_t c;
    wb2csr_t   b;
    c = '{re: 1'b0, we: s.we, num: s.num, wmask: s.wmask, wvalue: s.wvalue};
    b = '{ertn: s.ertn, wb_ex: s.ex, ecode: s.ecode, esubcode: s.esub, pc: s.pc, vaddr: s.vaddr};
    bus.wb_valid      = s.valid;
    bus.csr_ctrl      = c;
    bus.to_csr_in_bus = b;
  endtask

  task automatic apply(input stim_t s);
    drive(s);
    @(posedge clk);
    #1;
    drive(idle());
  endtask

  task automatic read_chk(input logic [13:0] num, input logic [31:0] exp, input string name);
    csr_ctrl_t c;
    c = '{re: 1'b1, we: 1'b0, num: num, wmask: 32'h0, wvalue: 32'h0};
    bus.csr_ctrl = c;
    #1;
    check32(name, bus.csr_rvalue, exp);
  endtask

  initial begin
    stim_t s;
    drive(idle());
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Reset state
    read_chk(CSR_CRMD, 32'h0000_0008, "rst_crmd");
    read_chk(CSR_TVAL, 32'hFFFF_FFFF, "rst_tval");
    read_chk(CSR_ESTAT, 32'h0000_0000, "rst_estat");
    read_chk(CSR_TID, 32'h1234_5678, "rst_tid");
    check1("rst_has_int", has_int, 1'b0);

    // Masked write; same-cycle read still sees the old value
    drive(wr(CSR_CRMD, 32'h0000_0003, 32'h0000_0007));
    #1 check32("crmd_same_cycle", bus.csr_rvalue, 32'h0000_0008);
    @(posedge clk);
    #1 drive(idle());
    read_chk(CSR_CRMD, 32'h0000_000B, "crmd_masked");

    vt[0]  = '{wr(CSR_CRMD, 32'hFFFF_FFFF, 32'hFFFF_FFFF), CSR_CRMD, 32'h0000_01FF, 1'b0, "crmd_all"};
    vt[1]  = '{wr(CSR_CRMD, 32'hFFFF_FFFF, 32'h0000_000F), CSR_CRMD, 32'h0000_000F, 1'b0, "crmd_f"};
    vt[2]  = '{wr(CSR_ECFG, 32'hFFFF_FFFF, 32'hFFFF_FFFF), CSR_ECFG, 32'h0000_1BFF, 1'b0, "ecfg_all"};
    vt[3]  = '{wr(CSR_ESTAT, 32'hFFFF_FFFF, 32'hFFFF_FFFF), CSR_ESTAT, 32'h0000_0003, 1'b1, "estat_swi"};
    vt[4]  = '{wr(CSR_ESTAT, 32'h0000_0003, 32'h0000_0000), CSR_ESTAT, 32'h0000_0000, 1'b0, "estat_clr"};
    vt[5]  = '{wr(CSR_EENTRY, 32'hFFFF_FFFF, 32'hFFFF_FFFF), CSR_EENTRY, 32'hFFFF_FFC0, 1'b0, "eentry"};
    vt[6]  = '{wr(CSR_PRMD, 32'hFFFF_FFFF, 32'h0000_00FF), CSR_PRMD, 32'h0000_0007, 1'b0, "prmd"};
    vt[7]  = '{wr(CSR_PRMD, 32'h0000_0000, 32'h0000_0000), CSR_PRMD, 32'h0000_0007, 1'b0, "prmd_nomask"};
    vt[8]  = '{wr(CSR_SAVE2, 32'hFFFF_FFFF, 32'hDEAD_BEEF), CSR_SAVE2, 32'hDEAD_BEEF, 1'b0, "save2"};
    vt[9]  = '{wr(CSR_TVAL, 32'hFFFF_FFFF, 32'h0000_0000), CSR_TVAL, 32'hFFFF_FFFF, 1'b0, "tval_ro"};
    vt[10] = '{wr(14'h099, 32'hFFFF_FFFF, 32'h5555_5555), 14'h099, 32'h0000_0000, 1'b0, "unmapped"};
    s = wr(CSR_SAVE0, 32'hFFFF_FFFF, 32'h0000_1111); s.valid = 1'b0;
    vt[11] = '{s, CSR_SAVE0, 32'h0000_0000, 1'b0, "save0_novalid"};
    vt[12] = '{wr(CSR_TID, 32'hFFFF_FFFF, 32'hCAFE_0001), CSR_TID, 32'hCAFE_0001, 1'b0, "tid"};
    s = exc(ECODE_ADE, ESUBCODE_ADEF, 32'h1C00_0200, 32'h0000_0055); s.valid = 1'b0;
    vt[13] = '{s, CSR_BADV, 32'h1C00_0200, 1'b0, "badv_adef"};
    s = exc(ECODE_ADE, ESUBCODE_ADEM, 32'h0000_0300, 32'h0000_2000);
    s.we = 1'b1; s.num = CSR_BADV; s.wmask = 32'hFFFF_FFFF; s.wvalue = 32'h0000_FFFF;
    vt[14] = '{s, CSR_BADV, 32'h0000_2000, 1'b0, "badv_adem"};
    vt[15] = '{exc(6'h0B, 9'h000, 32'h0000_0400, 32'h0000_0077), CSR_BADV, 32'h0000_2000, 1'b0, "badv_keep"};
    vt[16] = '{exc(6'h0B, 9'h005, 32'h0000_0500, 32'h0000_0000), CSR_ESTAT, 32'h014B_0000, 1'b0, "estat_code"};
    s = wr(CSR_SAVE1, 32'hFFFF_FFFF, 32'h0000_1234); s.ertn = 1'b1;
    vt[17] = '{s, CSR_SAVE1, 32'h0000_0000, 1'b0, "ertn_drops_we"};

    for (int i = 0; i < 18; i++) begin
      apply(vt[i].s);
      read_chk(vt[i].rd, vt[i].exp, vt[i].name);
      check1({vt[i].name, "_int"}, has_int, vt[i].exp_int);
    end

    // Exception commit with a dropped write, then ERTN
    apply(wr(CSR_CRMD, 32'hFFFF_FFFF, 32'h0000_000F));
    s = exc(ECODE_ALE, 9'h000, 32'h1C00_0100, 32'h0000_1003);
    s.we = 1'b1; s.num = CSR_CRMD; s.wmask = 32'hFFFF_FFFF; s.wvalue = 32'h0000_01FF;
    apply(s);
    read_chk(CSR_PRMD, 32'h0000_0007, "ex_prmd");
    read_chk(CSR_CRMD, 32'h0000_0008, "ex_crmd");
    read_chk(CSR_ERA, 32'h1C00_0100, "ex_era");
    read_chk(CSR_BADV, 32'h0000_1003, "ex_badv");
    read_chk(CSR_ESTAT, 32'h0009_0000, "ex_estat");
    check32("ex_entry", ex_entry, 32'hFFFF_FFC0);
    check32("ertn_entry", ertn_entry, 32'h1C00_0100);
    s = idle(); s.valid = 1'b1; s.ertn = 1'b1;
    apply(s);
    read_chk(CSR_CRMD, 32'h0000_000F, "ertn_crmd");

    // Periodic timer: InitVal=4 -> TVAL 0x10 .. 0, fire, reload, clear
    apply(wr(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_0013));
    read_chk(CSR_TVAL, 32'h0000_0010, "tmr_load");
    for (int k = 1; k <= 16; k++) begin
      apply(idle());
      read_chk(CSR_TVAL, 32'h0000_0010 - 32'(k), "tmr_count");
    end
    check1("tmr_pre_fire_int", has_int, 1'b0);
    apply(idle());
    check1("tmr_fire_int", has_int, 1'b1);
    read_chk(CSR_TVAL, 32'h0000_0010, "tmr_reload");
    read_chk(CSR_ESTAT, 32'h0009_0800, "tmr_fire_estat");
    apply(wr(CSR_TICLR, 32'hFFFF_FFFF, 32'h0000_0001));
    check1("ticlr_int", has_int, 1'b0);
    read_chk(CSR_TVAL, 32'h0000_000F, "ticlr_tval");

    // One-shot timer: fires once, TICLR in the fire cycle loses, then parks
    apply(wr(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_0009));
    read_chk(CSR_TVAL, 32'h0000_0008, "os_load");
    repeat (8) apply(idle());
    read_chk(CSR_TVAL, 32'h0000_0000, "os_zero");
    apply(wr(CSR_TICLR, 32'hFFFF_FFFF, 32'h0000_0001));
    check1("os_fire_beats_clr", has_int, 1'b1);
    read_chk(CSR_TVAL, 32'hFFFF_FFFF, "os_park");
    apply(wr(CSR_TICLR, 32'hFFFF_FFFF, 32'h0000_0001));
    check1("os_clr", has_int, 1'b0);
    for (int k = 0; k < 3; k++) begin
      apply(idle());
      read_chk(CSR_TVAL, 32'hFFFF_FFFF, "os_hold");
      check1("os_no_refire", has_int, 1'b0);
    end

    // Reset in the middle of a countdown, with a hardware interrupt pending
    apply(wr(CSR_TCFG, 32'hFFFF_FFFF, 32'h0000_0009));
    repeat (2) apply(idle());
    hw_int = 8'h05;
    apply(idle());
    read_chk(CSR_TVAL, 32'h0000_0005, "mid_tval");
    read_chk(CSR_ESTAT, 32'h0009_0014, "hw_int_estat");
    check1("hw_int_has_int", has_int, 1'b1);
    resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    read_chk(CSR_TCFG, 32'h0000_0000, "rst2_tcfg_rd");
    check1("rst2_tcfg_en", bus.csr_rvalue[0], 1'b0);
    read_chk(CSR_TVAL, 32'hFFFF_FFFF, "rst2_tval");
    read_chk(CSR_ESTAT, 32'h0000_0000, "rst2_estat");
    read_chk(CSR_CRMD, 32'h0000_0008, "rst2_crmd");
    read_chk(CSR_TID, 32'h1234_5678, "rst2_tid");
    check1("rst2_has_int", has_int, 1'b0);
    hw_int = 8'h00;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
